btn_step_conditioner: RTL and testbench
=======================================

Name: btn_step_conditioner

Overview:
- Upstream stage for the JK-based state machines: turns a raw push-button/switch into the clean step input `x` and supplies the slow step tick those machines advance on.
- Functions: 2-flop synchronizer, debounce FSM, press-event latch held until the next tick, and a tick divider.
- Replaces the free-running slow clock with a single-clock tick enable, so downstream logic stays on `clk`.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable `clk` cycles required to accept a level change (must be >= 1)
- TICK_DIV, 50000000, `clk` cycles per `tick` pulse (must be >= 1)
- REPEAT_TICKS, 4, ticks between auto-repeat events (used only with the optional feature; must be >= 1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- btn_raw  input  1  asynchronous raw button/switch level
- x_clean  output  1  debounced, synchronized button level
- x_step  output  1  press-event flag, held until consumed at a tick; drives downstream `x`
- tick  output  1  one-cycle step enable, period TICK_DIV
- press  output  1  one-cycle pulse on each accepted press

Behaviour:
- Reset (reset=0, asynchronous):
  - All flops cleared; FSM in IDLE; counters at 0.
  - Outputs x_clean=0, x_step=0, tick=0, press=0.
  - Release is sampled on the rising edge of `clk`; cycle 0 is the first edge with reset=1.
- Synchronizer: btn_raw -> s1 -> s2 on consecutive edges. The FSM sees only s2.
- Debounce FSM (registered state, counter `cnt`):
  - IDLE: s2=1 -> PRESS_CHK, cnt=1; else stay.
  - PRESS_CHK: s2=0 -> IDLE, cnt=0. Else, if cnt==DEBOUNCE_CYCLES -> HELD and press=1 for that one cycle. Else cnt+=1.
  - HELD: s2=0 -> RELEASE_CHK, cnt=1; else stay.
  - RELEASE_CHK: s2=1 -> HELD, cnt=0, no new press. Else, if cnt==DEBOUNCE_CYCLES -> IDLE. Else cnt+=1.
  - x_clean = 1 in HELD or RELEASE_CHK; registered decode, asserted the cycle the state is entered.
  - Latency: a btn_raw rise held stable produces x_clean=1 exactly DEBOUNCE_CYCLES+3 edges after btn_raw is first sampled high. Falling latency is the same.
  - Any glitch shorter than DEBOUNCE_CYCLES stable cycles causes no output change.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 on the cycle the counter equals TICK_DIV-1.
  - First tick occurs on edge TICK_DIV-1 after reset release.
  - TICK_DIV=1 gives tick=1 every cycle after reset.
- x_step latch:
  - Set on the cycle after press=1.
  - Cleared on the cycle after a tick=1 cycle during which x_step was already 1, so downstream sampling on tick sees it exactly once.
  - Press and tick in the same cycle: the press wins; x_step sets and survives to the following tick.
  - A second press while x_step=1 is absorbed; there is no event queue.
- Reset asserted mid-debounce or mid-event: immediate clear, with no pulse emitted on release.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN
- Defined: while the FSM is in HELD, a tick counter counts ticks. Every REPEAT_TICKS ticks it re-arms x_step (and pulses press), as if a new press occurred. The counter clears on leaving HELD.
- Undefined: exactly one x_step event per accepted press, and the repeat counter is not synthesized.

Test Plan:
- Reset: hold reset=0 for 5 cycles with btn_raw=1 -> all outputs 0 throughout. After release, x_clean rises at edge DEBOUNCE_CYCLES+3. (DEBOUNCE_CYCLES=4, TICK_DIV=8 for all tests.)
- Bounce: toggle btn_raw 1/0 every 2 cycles for 20 cycles, then hold 1 -> no press during bouncing. A single press and x_clean=1 occur exactly 7 edges after the final rise.
- Event hold: press accepted at cycle 10 -> x_step=1 from cycle 11 through the first tick (cycle 15), and 0 at cycle 16. tick pulses at cycles 7, 15, 23.
- Press coincident with tick: press=1 at cycle 15 -> x_step=1 at 16, held through the tick at 23, cleared at 24.
- Release glitch: while HELD, drive btn_raw=0 for 3 cycles, then back to 1 -> x_clean stays 1 and no new press.
- Auto-repeat (BTN_AUTOREPEAT_EN, REPEAT_TICKS=2): hold the button for 60 cycles -> one initial press, then a press every 16 cycles while held. Without the macro: exactly one press.

Source files
------------

// File: rtl/btn_step_conditioner.sv
// btn_step_conditioner: raw button -> 2-flop synchronizer -> debounce FSM ->
// press-event latch (x_step) held until consumed at the next slow tick, plus
// the tick divider that replaces the old free-running slow clock.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while held).
module btn_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_DIV        = 50000000,
  parameter int REPEAT_TICKS    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic x_clean,
  output logic x_step,
  output logic tick,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);

  // Reject nonsensical configurations at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || TICK_DIV < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("btn_step_conditioner: DEBOUNCE_CYCLES, TICK_DIV and REPEAT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            x_clean_q, x_clean_d;
  logic            press_q, press_d;
  logic            x_step_q, x_step_d;
  logic            tick_q, tick_d;
  logic            accept;

  // Synchronizer input stage.
  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
  end

  // Debounce FSM next-state logic; it only ever looks at the synchronized s2.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_CHK: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register stage: x_clean decodes the settled state, and a press is
  // accepted on the first cycle in HELD before x_clean has followed, so a
  // RELEASE_CHK -> HELD bounce (x_clean already 1) never yields a new press.
  always_comb begin
    x_clean_d = (state_q == HELD) || (state_q == RELEASE_CHK);
    accept    = (state_q == HELD) && !x_clean_q;
  end

  // Tick divider: free-running 0..TICK_DIV-1, registered terminal-count pulse.
  always_comb begin
    div_d  = (div_q == DIV_MAX) ? '0 : div_q + DIV_ONE;
    tick_d = (div_q == DIV_MAX);
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS - 1);
  localparam logic [RW-1:0] REP_ONE = RW'(1);

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_fire;

  // Auto-repeat: count ticks spent in HELD, fire a synthetic press every REPEAT_TICKS.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != HELD) begin
      rep_d = '0;
    end else if (tick_q) begin
      if (rep_q == REP_MAX) begin
        rep_d    = '0;
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + REP_ONE;
      end
    end
  end

  // Auto-repeat tick counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  // Press pulse from an accepted press or an auto-repeat event.
  always_comb begin
    press_d = accept || rep_fire;
  end
`else
  // Press pulse from an accepted press only.
  always_comb begin
    press_d = accept;
  end
`endif

  // x_step latch: a press always wins; otherwise a tick seen while set consumes it.
  always_comb begin
    x_step_d = x_step_q;
    if (press_q) begin
      x_step_d = 1'b1;
    end else if (tick_q && x_step_q) begin
      x_step_d = 1'b0;
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      x_clean_q <= 1'b0;
      press_q   <= 1'b0;
      x_step_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      x_clean_q <= x_clean_d;
      press_q   <= press_d;
      x_step_q  <= x_step_d;
      tick_q    <= tick_d;
    end
  end

  assign x_clean = x_clean_q;
  assign x_step  = x_step_q;
  assign tick    = tick_q;
  assign press   = press_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Self-checking bench for btn_step_conditioner with DEBOUNCE_CYCLES=4,
// TICK_DIV=8, REPEAT_TICKS=2. Cycle k = sampled 1 time unit after edge k,
// edge 0 being the first rising edge with reset released.
module tb_btn_step_conditioner;

  localparam int D = 4;
  localparam int T = 8;
  localparam int R = 2;

  logic clk;
  logic reset;
  logic btn_raw;
  logic x_clean;
  logic x_step;
  logic tick;
  logic press;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   first;
    int   last;
    logic btn;
    logic xc;
    logic xs;
    logic tk;
    logic pr;
  } seg_t;

  seg_t segs[11];

  btn_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV       (T),
    .REPEAT_TICKS   (R)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .x_clean(x_clean),
    .x_step (x_step),
    .tick   (tick),
    .press  (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cyc,
                         input logic xc, input logic xs, input logic tk, input logic pr);
    chk({tag, ".x_clean"}, cyc, x_clean, xc);
    chk({tag, ".x_step"},  cyc, x_step,  xs);
    chk({tag, ".tick"},    cyc, tick,    tk);
    chk({tag, ".press"},   cyc, press,   pr);
  endtask

  task automatic step(input logic b);
    btn_raw = b;
    @(posedge clk);
    #1;
  endtask

  // Hold reset for a few edges with btn_raw low, release right after an edge.
  task automatic restart();
    reset   = 1'b0;
    btn_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int npress;

    // Scenario A: btn high from release; coincident press/tick at 7,
    // release glitch 18..20, final release at 24.
    segs[0]  = '{0,  6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    segs[1]  = '{7,  7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    segs[2]  = '{8,  14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    segs[3]  = '{15, 15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    segs[4]  = '{16, 17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    segs[5]  = '{18, 20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    segs[6]  = '{21, 22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    segs[7]  = '{23, 23, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    segs[8]  = '{24, 30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    segs[9]  = '{31, 31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    segs[10] = '{32, 33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held 5 cycles with btn_raw=1: everything stays low.
    reset   = 1'b0;
    btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_all("reset", i, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;

    for (int s = 0; s < 11; s++) begin
      for (int k = segs[s].first; k <= segs[s].last; k++) begin
        step(segs[s].btn);
        chk_all("table", k, segs[s].xc, segs[s].xs, segs[s].tk, segs[s].pr);
      end
    end

    // Event hold: btn rises before edge 3 -> press at 10, x_step 11..15.
    restart();
    for (int k = 0; k <= 24; k++) begin
      step(k >= 3);
      chk_all("hold", k, (k >= 10), (k >= 11 && k <= 15), (k % T == T - 1), (k == 10));
    end

    // Press coincident with tick at 15: x_step 16..23, cleared at 24.
    restart();
    for (int k = 0; k <= 25; k++) begin
      step(k >= 8);
      chk_all("coinc", k, (k >= 15), (k >= 16 && k <= 23), (k % T == T - 1), (k == 15));
    end

    // Bounce: toggle every 2 cycles for 20 cycles, then hold high from 20.
    restart();
    npress = 0;
    for (int k = 0; k <= 27; k++) begin
      step((k >= 20) ? 1'b1 : (((k / 2) % 2) == 0));
      if (k < 27) begin
        if (press === 1'b1) npress++;
        if (x_clean !== 1'b0) chk("bounce.x_clean", k, x_clean, 1'b0);
      end else begin
        chk("bounce.press_count", k, (npress == 0), 1'b1);
        chk("bounce.press", k, press, 1'b1);
        chk("bounce.x_clean", k, x_clean, 1'b1);
      end
    end

    // Reset mid-event (x_step set), then mid-debounce: immediate clear, no pulse after.
    restart();
    for (int k = 0; k <= 9; k++) step(1'b1);
    chk("midevt.x_step_before", 9, x_step, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_all("midevt", 9, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1);
    #2 reset = 1'b0;
    #1;
    chk_all("middeb", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    restart();
    npress = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0);
      if (press === 1'b1 || x_step === 1'b1 || x_clean === 1'b1) npress++;
    end
    chk("postreset.quiet", 11, (npress == 0), 1'b1);

    // Long hold of 60 cycles: one press, or a press every 16 cycles with auto-repeat.
    restart();
    npress = 0;
    for (int k = 0; k < 60; k++) begin
      step(1'b1);
      if (press === 1'b1) npress++;
    end
`ifdef BTN_AUTOREPEAT_EN
    chk("longhold.press_count_is_4", 59, (npress == 4), 1'b1);
`else
    chk("longhold.press_count_is_1", 59, (npress == 1), 1'b1);
`endif
    chk("longhold.x_clean", 59, x_clean, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
